// File: rtl/fwd_pkg.sv
// Shared types for the Decode/Execute forwarding and hazard block:
// operand select codes, retired-write history entries, hazard FSM states.
package fwd_pkg;

  localparam int XLEN   = 32;
  localparam int REG_AW = 5;

  typedef enum logic [1:0] {
    FWD_RF   = 2'd0,
    FWD_WB   = 2'd1,
    FWD_MEM  = 2'd2,
    FWD_HIST = 2'd3
  } fwd_sel_t;

  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] rd;
    logic [XLEN-1:0]   data;
  } hist_entry_t;

  typedef enum logic {
    HZ_IDLE,
    HZ_STALL
  } hz_state_t;

endpackage

// File: rtl/fwd_operand_mux.sv
// Resolves one Execute source operand: Memory > Writeback > history
// (entry 0 newest) > regfile. Ports: rs, rf_data, M/W write info,
// history arrays in; operand value and select code out.
module fwd_operand_mux
  import fwd_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int ADDR_W  = 5,
  parameter int HD      = 2,
  parameter bit HIST_EN = 1'b0
) (
  input  logic [ADDR_W-1:0]         rs,
  input  logic [WIDTH-1:0]          rf_data,
  input  logic [ADDR_W-1:0]         rd_m,
  input  logic                      regwrite_m,
  input  logic [WIDTH-1:0]          alu_result_m,
  input  logic [ADDR_W-1:0]         rd_w,
  input  logic                      regwrite_w,
  input  logic [WIDTH-1:0]          result_w,
  input  logic [HD-1:0]             hist_valid,
  input  logic [HD-1:0][ADDR_W-1:0] hist_rd,
  input  logic [HD-1:0][WIDTH-1:0]  hist_data,
  output logic [WIDTH-1:0]          operand,
  output fwd_sel_t                  sel
);

  logic rs_nz;
  assign rs_nz = |rs;

  always_comb begin
    operand = rf_data;
    sel     = FWD_RF;
    if (rs_nz) begin
      // Walk oldest to newest so the newest duplicate wins.
      if (HIST_EN) begin
        for (int k = HD - 1; k >= 0; k--) begin
          if (hist_valid[k] && hist_rd[k] == rs) begin
            operand = hist_data[k];
            sel     = FWD_HIST;
          end
        end
      end
      if (regwrite_w && rd_w == rs) begin
        operand = result_w;
        sel     = FWD_WB;
      end
      if (regwrite_m && rd_m == rs) begin
        operand = alu_result_m;
        sel     = FWD_MEM;
      end
    end
  end

endmodule

// File: rtl/fwd_hazard_unit.sv
// Operand forwarding plus load-use stall / branch flush control.
// Ports: rs_d/rs_e, E/M/W write info, pc_src_e in; src_e, fwd_sel_e,
// stall_f/d, flush_d/e out. FWD_HIST_EN enables the history buffer.
module fwd_hazard_unit
  import fwd_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int ADDR_W     = 5,
  parameter int NUM_SRC    = 2,
  parameter int HIST_DEPTH = 2,
  parameter int LOAD_LAT   = 1
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [NUM_SRC-1:0][ADDR_W-1:0]  rs_d,
  input  logic [NUM_SRC-1:0][ADDR_W-1:0]  rs_e,
  input  logic [NUM_SRC-1:0][WIDTH-1:0]   rf_data_e,
  input  logic [ADDR_W-1:0]               rd_e,
  input  logic                            regwrite_e,
  input  logic                            memread_e,
  input  logic [ADDR_W-1:0]               rd_m,
  input  logic                            regwrite_m,
  input  logic [WIDTH-1:0]                alu_result_m,
  input  logic [ADDR_W-1:0]               rd_w,
  input  logic                            regwrite_w,
  input  logic [WIDTH-1:0]                result_w,
  input  logic                            pc_src_e,
  output logic [NUM_SRC-1:0][WIDTH-1:0]   src_e,
  output logic [NUM_SRC-1:0][1:0]         fwd_sel_e,
  output logic                            stall_f,
  output logic                            stall_d,
  output logic                            flush_d,
  output logic                            flush_e
);

`ifdef FWD_HIST_EN
  localparam bit HIST_EN = 1'b1;
`else
  localparam bit HIST_EN = 1'b0;
`endif
  localparam int HD = HIST_EN ? HIST_DEPTH : 1;
  localparam logic [2:0] LAT_M1 = 3'(LOAD_LAT - 1);

  logic [HD-1:0]             hist_valid;
  logic [HD-1:0][ADDR_W-1:0] hist_rd;
  logic [HD-1:0][WIDTH-1:0]  hist_data;

  generate
    if (HIST_EN) begin : g_hist
      hist_entry_t hist_q [HD];
      logic        push;
      assign push = regwrite_w && (rd_w != '0);

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          for (int k = 0; k < HD; k++)
            hist_q[k].valid <= 1'b0;
        end else if (push) begin
          hist_q[0] <= '{1'b1, REG_AW'(rd_w), XLEN'(result_w)};
          for (int k = 1; k < HD; k++)
            hist_q[k] <= hist_q[k-1];
        end
      end

      always_comb begin
        for (int k = 0; k < HD; k++) begin
          hist_valid[k] = hist_q[k].valid;
          hist_rd[k]    = ADDR_W'(hist_q[k].rd);
          hist_data[k]  = WIDTH'(hist_q[k].data);
        end
      end
    end else begin : g_nohist
      assign hist_valid = '0;
      assign hist_rd    = '0;
      assign hist_data  = '0;
    end
  endgenerate

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
    fwd_sel_t sel;
    fwd_operand_mux #(
      .WIDTH(WIDTH), .ADDR_W(ADDR_W),
      .HD(HD), .HIST_EN(HIST_EN)
    ) u_mux (
      .rs(rs_e[i]),
      .rf_data(rf_data_e[i]),
      .rd_m(rd_m),
      .regwrite_m(regwrite_m),
      .alu_result_m(alu_result_m),
      .rd_w(rd_w),
      .regwrite_w(regwrite_w),
      .result_w(result_w),
      .hist_valid(hist_valid),
      .hist_rd(hist_rd),
      .hist_data(hist_data),
      .operand(src_e[i]),
      .sel(sel)
    );
    assign fwd_sel_e[i] = sel;
  end

  // regwrite_e is part of the stage bundle but a load always writes,
  // so only memread_e gates detection.
  logic unused;
  assign unused = regwrite_e;

  logic load_use;
  always_comb begin
    load_use = 1'b0;
    for (int i = 0; i < NUM_SRC; i++)
      if (rs_d[i] == rd_e) load_use = 1'b1;
    load_use = load_use && memread_e && (rd_e != '0);
  end

  hz_state_t state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic       stall;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= HZ_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    stall   = 1'b0;
    flush_d = 1'b0;
    flush_e = 1'b0;
    if (pc_src_e) begin
      flush_d = 1'b1;
      flush_e = 1'b1;
      state_d = HZ_IDLE;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        HZ_IDLE: begin
          if (load_use) begin
            stall   = 1'b1;
            flush_e = 1'b1;
            cnt_d   = LAT_M1;
            state_d = (LAT_M1 == '0) ? HZ_IDLE : HZ_STALL;
          end
        end
        HZ_STALL: begin
          stall   = 1'b1;
          flush_e = 1'b1;
          cnt_d   = cnt_q - 3'd1;
          if (cnt_q <= 3'd1) state_d = HZ_IDLE;
        end
      endcase
    end
    if (!rst_n) begin
      stall   = 1'b0;
      flush_d = 1'b0;
      flush_e = 1'b0;
    end
  end

  assign stall_f = stall;
  assign stall_d = stall;

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Scoreboard bench for fwd_hazard_unit: driver pushes model predictions,
// a monitor pops and compares each cycle. Honours FWD_HIST_EN.
module tb_fwd_hazard_unit;
  import fwd_pkg::*;

  localparam int WIDTH      = 32;
  localparam int ADDR_W     = 5;
  localparam int NUM_SRC    = 2;
  localparam int HIST_DEPTH = 2;
  localparam int LOAD_LAT   = 3;

  logic                           clk = 1'b0;
  logic                           rst_n;
  logic [NUM_SRC-1:0][ADDR_W-1:0] rs_d, rs_e;
  logic [NUM_SRC-1:0][WIDTH-1:0]  rf_data_e;
  logic [ADDR_W-1:0]              rd_e, rd_m, rd_w;
  logic                           regwrite_e, memread_e;
  logic                           regwrite_m, regwrite_w, pc_src_e;
  logic [WIDTH-1:0]               alu_result_m, result_w;
  logic [NUM_SRC-1:0][WIDTH-1:0]  src_e;
  logic [NUM_SRC-1:0][1:0]        fwd_sel_e;
  logic                           stall_f, stall_d, flush_d, flush_e;

  fwd_hazard_unit #(
    .WIDTH(WIDTH), .ADDR_W(ADDR_W), .NUM_SRC(NUM_SRC),
    .HIST_DEPTH(HIST_DEPTH), .LOAD_LAT(LOAD_LAT)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .rs_d(rs_d), .rs_e(rs_e), .rf_data_e(rf_data_e),
    .rd_e(rd_e), .regwrite_e(regwrite_e), .memread_e(memread_e),
    .rd_m(rd_m), .regwrite_m(regwrite_m),
    .alu_result_m(alu_result_m),
    .rd_w(rd_w), .regwrite_w(regwrite_w), .result_w(result_w),
    .pc_src_e(pc_src_e),
    .src_e(src_e), .fwd_sel_e(fwd_sel_e),
    .stall_f(stall_f), .stall_d(stall_d),
    .flush_d(flush_d), .flush_e(flush_e)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [NUM_SRC-1:0][WIDTH-1:0] src;
    logic [NUM_SRC-1:0][1:0]       sel;
    logic [3:0]                    hz;
  } exp_t;

  exp_t        sbq[$];
  int          checks   = 0;
  int          failures = 0;
  bit          done     = 0;

  // Reference state: retired writes newest-first, remaining stall cycles.
  int unsigned h_rd[$];
  logic [31:0] h_data[$];
  int          stall_left = 0;

  task automatic quiet();
    rst_n = 1'b1;
    for (int i = 0; i < NUM_SRC; i++) begin
      rs_d[i]      = '0;
      rs_e[i]      = '0;
      rf_data_e[i] = $urandom;
    end
    rd_e = '0; regwrite_e = 0; memread_e = 0;
    rd_m = '0; regwrite_m = 0; alu_result_m = $urandom;
    rd_w = '0; regwrite_w = 0; result_w = $urandom;
    pc_src_e = 0;
  endtask

  task automatic rand_inputs();
    rst_n = ($urandom_range(0, 39) != 0);
    for (int i = 0; i < NUM_SRC; i++) begin
      rs_d[i]      = ADDR_W'($urandom_range(0, 7));
      rs_e[i]      = ADDR_W'($urandom_range(0, 7));
      rf_data_e[i] = $urandom;
    end
    rd_e = ADDR_W'($urandom_range(0, 7));
    regwrite_e = 1'($urandom);
    memread_e  = ($urandom_range(0, 3) == 0);
    rd_m = ADDR_W'($urandom_range(0, 7));
    regwrite_m = ($urandom_range(0, 2) == 0);
    alu_result_m = $urandom;
    rd_w = ADDR_W'($urandom_range(0, 7));
    regwrite_w = ($urandom_range(0, 1) == 0);
    result_w = $urandom;
    pc_src_e = ($urandom_range(0, 11) == 0);
  endtask

  // Predict this cycle's outputs, queue them, then advance the model
  // across the coming clock edge.
  task automatic step();
    exp_t e;
    bit   lu;
    int   a;
    for (int i = 0; i < NUM_SRC; i++) begin
      a = int'(rs_e[i]);
      e.src[i] = rf_data_e[i];
      e.sel[i] = 2'd0;
      if (a != 0) begin
        if (regwrite_m && int'(rd_m) == a) begin
          e.src[i] = alu_result_m; e.sel[i] = 2'd2;
        end else if (regwrite_w && int'(rd_w) == a) begin
          e.src[i] = result_w; e.sel[i] = 2'd1;
        end else begin
`ifdef FWD_HIST_EN
          for (int k = 0; k < h_rd.size(); k++) begin
            if (h_rd[k] == a) begin
              e.src[i] = h_data[k]; e.sel[i] = 2'd3;
              break;
            end
          end
`endif
        end
      end
    end
    lu = 0;
    for (int i = 0; i < NUM_SRC; i++)
      if (rs_d[i] == rd_e) lu = 1;
    lu = lu && memread_e && rd_e != 0;
    e.hz = 4'b0000;
    if (!rst_n) begin
      stall_left = 0;
      h_rd.delete();
      h_data.delete();
    end else begin
      if (pc_src_e) begin
        e.hz = 4'b0011;
        stall_left = 0;
      end else if (stall_left > 0) begin
        e.hz = 4'b1101;
        stall_left--;
      end else if (lu) begin
        e.hz = 4'b1101;
        stall_left = LOAD_LAT - 1;
      end
      if (regwrite_w && rd_w != 0) begin
        h_rd.push_front(int'(rd_w));
        h_data.push_front(result_w);
        if (h_rd.size() > HIST_DEPTH) begin
          void'(h_rd.pop_back());
          void'(h_data.pop_back());
        end
      end
    end
    sbq.push_back(e);
  endtask

  // Monitor: outputs are stable 2 time units after the driving edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        for (int i = 0; i < NUM_SRC; i++) begin
          checks++;
          if (src_e[i] !== e.src[i]) begin
            failures++;
            $display("FAIL src%0d got=%h want=%h t=%0t",
                     i, src_e[i], e.src[i], $time);
          end
          checks++;
          if (fwd_sel_e[i] !== e.sel[i]) begin
            failures++;
            $display("FAIL sel%0d got=%0d want=%0d t=%0t",
                     i, fwd_sel_e[i], e.sel[i], $time);
          end
        end
        checks++;
        if ({stall_f, stall_d, flush_d, flush_e} !== e.hz) begin
          failures++;
          $display("FAIL hazard got=%b want=%b t=%0t",
                   {stall_f, stall_d, flush_d, flush_e}, e.hz, $time);
        end
      end
    end
  end

  task automatic cyc_begin();
    @(negedge clk);
    quiet();
  endtask

  initial begin
    int guard;
    quiet();
    rst_n = 1'b0;
    @(posedge clk);
    // Reset cycle with outputs checked.
    cyc_begin(); rst_n = 1'b0; step();

    // Memory beats Writeback.
    cyc_begin();
    rs_e[0] = 5; rd_m = 5; regwrite_m = 1; alu_result_m = 32'h11;
    rd_w = 5; regwrite_w = 1; result_w = 32'h22;
    step();

    // x0 never forwards.
    cyc_begin();
    rs_e[1] = 0; rd_m = 0; regwrite_m = 1;
    step();

    // History lookup two cycles after a Writeback of x7.
    cyc_begin(); rd_w = 7; regwrite_w = 1; result_w = 32'hAB; step();
    cyc_begin(); step();
    cyc_begin(); rs_e[0] = 7; step();

    // Plain load-use: three stall cycles then idle.
    cyc_begin(); memread_e = 1; rd_e = 9; rs_d[1] = 9; step();
    repeat (4) begin cyc_begin(); step(); end

    // Branch in the second stall cycle.
    cyc_begin(); memread_e = 1; rd_e = 9; rs_d[1] = 9; step();
    cyc_begin(); pc_src_e = 1; step();
    repeat (2) begin cyc_begin(); step(); end

    // Reset mid-stall clears stall and history.
    cyc_begin(); rd_w = 7; regwrite_w = 1; result_w = 32'hCD; step();
    cyc_begin(); memread_e = 1; rd_e = 9; rs_d[0] = 9; step();
    cyc_begin(); rst_n = 1'b0; step();
    cyc_begin(); rs_e[0] = 7; step();
    cyc_begin(); step();

    // LOAD_LAT boundary: back-to-back loads, re-detect right after.
    cyc_begin(); memread_e = 1; rd_e = 3; rs_d[0] = 3; step();
    repeat (2) begin
      cyc_begin(); memread_e = 1; rd_e = 3; rs_d[0] = 3; step();
    end
    cyc_begin(); memread_e = 1; rd_e = 3; rs_d[0] = 3; step();
    cyc_begin(); step();

    for (int n = 0; n < 2000; n++) begin
      @(negedge clk);
      rand_inputs();
      step();
    end

    guard = 0;
    while (sbq.size() > 0 && guard < 10) begin
      @(posedge clk);
      guard++;
    end
    #5;
    checks++;
    if (sbq.size() != 0) begin
      failures++;
      $display("FAIL drain left=%0d want=0", sbq.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fwd_hazard_unit.md
# fwd_hazard_unit

Parametrised operand-forwarding and hazard-control block for the pipelined RV32I core, placed at the Decode/Execute boundary. Resolves each Execute-stage source operand from Memory, Writeback or a short retired-write history buffer, falling back to register-file data when no newer value exists. Generates load-use stall/flush sequences with configurable bubble count and branch-taken flushes. Covers any number of source operands.

## Interface
Parameters:
- `WIDTH`, 32, data width.
- `ADDR_W`, 5, register address width.
- `NUM_SRC`, 2, number of source operands resolved in Execute.
- `HIST_DEPTH`, 2, retired-write history entries; minimum 1.
- `LOAD_LAT`, 1, bubbles inserted per load-use hazard; minimum 1, maximum 7.

Ports:
- `clk`  in  1  clock, rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `rs_d`  in  NUM_SRC×ADDR_W  Decode-stage source addresses.
- `rs_e`  in  NUM_SRC×ADDR_W  Execute-stage source addresses.
- `rf_data_e`  in  NUM_SRC×WIDTH  register-file read data carried into Execute.
- `rd_e`, `regwrite_e`, `memread_e`  in  ADDR_W/1/1  Execute destination, write enable, load flag.
- `rd_m`, `regwrite_m`, `alu_result_m`  in  ADDR_W/1/WIDTH  Memory-stage write.
- `rd_w`, `regwrite_w`, `result_w`  in  ADDR_W/1/WIDTH  Writeback-stage write.
- `pc_src_e`  in  1  branch/jump taken in Execute.
- `src_e`  out  NUM_SRC×WIDTH  resolved operands.
- `fwd_sel_e`  out  NUM_SRC×2  source select per operand: 0 regfile, 1 Writeback, 2 Memory, 3 history.
- `stall_f`, `stall_d`  out  1  hold Fetch/Decode registers.
- `flush_d`, `flush_e`  out  1  clear Decode/Execute registers.

## Operation
- Per operand, priority: Memory > Writeback > history (newest first) > `rf_data_e`. A stage matches only when its write enable is high, its `rd` equals `rs_e[i]`, and `rd` ≠ 0. `rs_e[i]`=0 always yields sel 0.
- History: shift register of {valid, rd, data}. Each cycle with `regwrite_w` high and `rd_w`≠0, `{1, rd_w, result_w}` is pushed at entry 0; the oldest entry is discarded. Duplicate rds permitted; the newest one wins.
- Load-use detection: `memread_e` & `rd_e`≠0 & `rd_e` matches any `rs_d[i]`.
- FSM states: IDLE, STALL.
  - IDLE→STALL on detection; counter loaded with LOAD_LAT−1. During the detection cycle `stall_f`=`stall_d`=`flush_e`=1.
  - STALL: same three outputs asserted; counter decrements; at 0 return to IDLE. Detection is not re-evaluated while in STALL.
  - `pc_src_e` high in any state: `flush_d`=`flush_e`=1, `stall_f`=`stall_d`=0, FSM forced to IDLE, counter cleared. Branch overrides stall.
- `rst_n` low: FSM IDLE, counter 0, all history valids cleared. `stall_*`/`flush_*` forced 0 during the reset cycle. `src_e` still resolves combinationally from the stage inputs.

## Timing
- `src_e`, `fwd_sel_e`: combinational, zero latency.
- Hazard outputs: combinational from inputs and registered state.
- Load-use with LOAD_LAT=N: exactly N consecutive cycles of stall, starting in the detection cycle.
- History write is visible to the Execute-stage lookup on the cycle after `regwrite_w`.
- Reset asserted mid-stall: next cycle IDLE, no residual stall.

## Configuration
- `FWD_HIST_EN` defined: history buffer present; sel code 3 reachable.
- Undefined: no history storage. Priority is Memory > Writeback > regfile. Sel 3 is never produced. `HIST_DEPTH` is ignored.

## Structure
- Package `fwd_pkg`: `fwd_sel_t` enum (FWD_RF, FWD_WB, FWD_MEM, FWD_HIST), `hist_entry_t` struct, `hz_state_t` enum.
- Sub-module `fwd_operand_mux`: one instance per source. Takes `rs`, rf data, Memory/Writeback write info and the history array; outputs operand value and select.

## Test plan
- `rs_e[0]`=5, `rd_m`=5 with `regwrite_m`=1 and `alu_result_m`=0x11, `rd_w`=5 with `regwrite_w`=1 and `result_w`=0x22 → `src_e[0]`=0x11, sel=2.
- `rs_e[1]`=0 with `rd_m`=0 and `regwrite_m`=1 → `src_e[1]`=`rf_data_e[1]`, sel=0.
- `FWD_HIST_EN`: write x7=0xAB via Writeback; two cycles later `rs_e[0]`=7 with no Memory/Writeback match → 0xAB, sel=3.
- LOAD_LAT=3, `memread_e`=1, `rd_e`=9, `rs_d[1]`=9 → `stall_f`/`stall_d`/`flush_e` high for exactly 3 cycles, then low.
- LOAD_LAT=3: `pc_src_e`=1 in the second stall cycle → that cycle `flush_d`=`flush_e`=1 and `stall_*`=0; next cycle IDLE.
- `rst_n`=0 during STALL → next cycle all hazard outputs 0 and history empty (a lookup of a previously written register returns regfile data).
